// File: rtl/id_decode_stage.sv
// ---------------------------------------------------------------------------
// id_decode_stage
//
// Instruction-decode stage of a 5-stage MIPS pipeline. The stage contains
// the IF/ID pipeline register, the 32x32 register file, the main control
// decoder and the load-use hazard detector.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   instr_in, pc_incr_in     instruction and PC+4 from fetch
//   flush                    branch taken in MEM; squashes IF/ID
//   idex_mem_read, idex_rt   load in ID/EX (MemRead and its rt), for hazards
//   wb_reg_write,
//   wb_write_reg,
//   wb_write_data            register-file write port from write-back
//   pc_write                 0 = fetch must hold the PC this cycle
//   wb_ctrl                  {RegWrite, MemtoReg}
//   mem_ctrl                 {Branch, MemRead, MemWrite}
//   ex_ctrl                  {RegDst, ALUop[1:0], ALUSrc}
//   read1, read2             rs / rt operands, with write-through bypass
//   sign_ext                 sign-extended instr[15:0]
//   rd_out, rt_out           instr[15:11], instr[20:16]
//   pc_incr_out              PC+4 held in IF/ID
// ---------------------------------------------------------------------------
module id_decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_incr_in,
  input  logic        flush,
  input  logic        idex_mem_read,
  input  logic [4:0]  idex_rt,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_write_reg,
  input  logic [31:0] wb_write_data,
  output logic        pc_write,
  output logic [1:0]  wb_ctrl,
  output logic [2:0]  mem_ctrl,
  output logic [3:0]  ex_ctrl,
  output logic [31:0] read1,
  output logic [31:0] read2,
  output logic [31:0] sign_ext,
  output logic [4:0]  rd_out,
  output logic [4:0]  rt_out,
  output logic [31:0] pc_incr_out
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_BEQ   = 6'h04,
    OP_ADDI  = 6'h08,
    OP_ORI   = 6'h0D,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  // ALUop encodings seen by EX
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  // -------------------------------------------------------------------------
  // IF/ID pipeline register
  // -------------------------------------------------------------------------
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic        stall;

  logic [4:0] rs;
  logic [4:0] rt;
  assign rs = instr_q[25:21];
  assign rt = instr_q[20:16];

  // Flush takes priority over the stall hold so that a taken branch always
  // squashes the instruction behind it, even if that instruction was waiting
  // on a load.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst || flush) begin
      instr_q <= '0;
      pc_q    <= '0;
    end else if (!stall) begin
      instr_q <= instr_in;
      pc_q    <= pc_incr_in;
    end
  end

  // -------------------------------------------------------------------------
  // Register file
  // -------------------------------------------------------------------------
  logic [31:0] regs [32];

  always_ff @(posedge clk) begin
    // NOTE: the whole array is cleared on reset, which forces it into
    // flip-flops rather than a RAM macro; reset-to-zero registers are part of
    // the architectural contract here, so that cost is accepted.
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_reg_write && (wb_write_reg != 5'd0)) begin
      regs[wb_write_reg] <= wb_write_data;
    end
  end

  // Write-through bypass: a register written this cycle is visible on the
  // read ports before the edge, so WB and ID never need a separate forward.
  logic wb_fwd_ok;
  assign wb_fwd_ok = wb_reg_write && (wb_write_reg != 5'd0);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block can leave a value held and infer a latch.
    read1 = regs[rs];
    read2 = regs[rt];
    if (rs == 5'd0)                           read1 = '0;
    else if (wb_fwd_ok && wb_write_reg == rs) read1 = wb_write_data;
    if (rt == 5'd0)                           read2 = '0;
    else if (wb_fwd_ok && wb_write_reg == rt) read2 = wb_write_data;
  end

  // -------------------------------------------------------------------------
  // Load-use hazard detection
  // -------------------------------------------------------------------------
  assign stall = idex_mem_read && (idex_rt != 5'd0) &&
                 ((idex_rt == rs) || (idex_rt == rt));

  assign pc_write = flush || !stall;

  // -------------------------------------------------------------------------
  // Main control decoder
  // -------------------------------------------------------------------------
  logic [1:0] dec_wb;
  logic [2:0] dec_mem;
  logic [3:0] dec_ex;

  always_comb begin
    dec_wb  = 2'b00;
    dec_mem = 3'b000;
    dec_ex  = 4'b0000;
    // The all-zero word is a nop even though its opcode field is R-type.
    if (instr_q != 32'h0) begin
      case (instr_q[31:26])
        OP_RTYPE: begin dec_wb = 2'b10; dec_mem = 3'b000; dec_ex = {1'b1, ALU_FUNCT, 1'b0}; end
        OP_LW:    begin dec_wb = 2'b11; dec_mem = 3'b010; dec_ex = {1'b0, ALU_ADD,   1'b1}; end
        OP_SW:    begin dec_wb = 2'b00; dec_mem = 3'b001; dec_ex = {1'b0, ALU_ADD,   1'b1}; end
        OP_BEQ:   begin dec_wb = 2'b00; dec_mem = 3'b100; dec_ex = {1'b0, ALU_SUB,   1'b0}; end
        OP_ADDI:  begin dec_wb = 2'b10; dec_mem = 3'b000; dec_ex = {1'b0, ALU_ADD,   1'b1}; end
        OP_ORI:   begin dec_wb = 2'b10; dec_mem = 3'b000; dec_ex = {1'b0, ALU_OR,    1'b1}; end
        default:  begin dec_wb = 2'b00; dec_mem = 3'b000; dec_ex = 4'b0000; end
      endcase
    end
  end

  // A stall or flush sends a bubble into ID/EX by zeroing every control bit;
  // the data outputs stay driven since nothing downstream acts on them.
  logic bubble;
  assign bubble = stall || flush;

  assign wb_ctrl  = bubble ? 2'b00   : dec_wb;
  assign mem_ctrl = bubble ? 3'b000  : dec_mem;
  assign ex_ctrl  = bubble ? 4'b0000 : dec_ex;

  // -------------------------------------------------------------------------
  // Data outputs
  // -------------------------------------------------------------------------
  assign sign_ext    = {{16{instr_q[15]}}, instr_q[15:0]};
  assign rd_out      = instr_q[15:11];
  assign rt_out      = instr_q[20:16];
  assign pc_incr_out = pc_q;

endmodule

// File: tb/tb_id_decode_stage.sv
module tb_id_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_in;
  logic [31:0] pc_incr_in;
  logic        flush;
  logic        idex_mem_read;
  logic [4:0]  idex_rt;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        pc_write;
  logic [1:0]  wb_ctrl;
  logic [2:0]  mem_ctrl;
  logic [3:0]  ex_ctrl;
  logic [31:0] read1;
  logic [31:0] read2;
  logic [31:0] sign_ext;
  logic [4:0]  rd_out;
  logic [4:0]  rt_out;
  logic [31:0] pc_incr_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_decode_stage dut (
    .clk           (clk),
    .rst           (rst),
    .instr_in      (instr_in),
    .pc_incr_in    (pc_incr_in),
    .flush         (flush),
    .idex_mem_read (idex_mem_read),
    .idex_rt       (idex_rt),
    .wb_reg_write  (wb_reg_write),
    .wb_write_reg  (wb_write_reg),
    .wb_write_data (wb_write_data),
    .pc_write      (pc_write),
    .wb_ctrl       (wb_ctrl),
    .mem_ctrl      (mem_ctrl),
    .ex_ctrl       (ex_ctrl),
    .read1         (read1),
    .read2         (read2),
    .sign_ext      (sign_ext),
    .rd_out        (rd_out),
    .rt_out        (rt_out),
    .pc_incr_out   (pc_incr_out)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        mr;     // idex_mem_read
    logic [4:0]  irt;    // idex_rt
    logic [1:0]  wb;
    logic [2:0]  mem;
    logic [3:0]  ex;
    logic        pcw;
    logic [31:0] sx;
    logic [31:0] r1;
    logic [31:0] r2;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents an instruction to fetch outputs and lets one edge capture it.
  task automatic load(input logic [31:0] i, input logic [31:0] p);
    instr_in   = i;
    pc_incr_in = p;
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    wb_reg_write  = 1'b1;
    wb_write_reg  = a;
    wb_write_data = d;
    @(posedge clk);
    #1;
    wb_reg_write  = 1'b0;
  endtask

  task automatic check_bundles(input string tag, input logic [1:0] wb,
                               input logic [2:0] mem, input logic [3:0] ex);
    check({tag, ".wb"},  {30'd0, wb_ctrl},  {30'd0, wb});
    check({tag, ".mem"}, {29'd0, mem_ctrl}, {29'd0, mem});
    check({tag, ".ex"},  {28'd0, ex_ctrl},  {28'd0, ex});
  endtask

  initial begin
    // Decode sweep: lw/sw/beq/addi/ori use rs=8 (0xDEADBEEF), rt=9 (0x99).
    vecs[0]  = '{"lw",      32'h8D09_8000, 1'b0, 5'd0,  2'b11, 3'b010, 4'b0001, 1'b1, 32'hFFFF_8000, 32'hDEAD_BEEF, 32'h99};
    vecs[1]  = '{"sw",      32'hAD09_0004, 1'b0, 5'd0,  2'b00, 3'b001, 4'b0001, 1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 32'h99};
    vecs[2]  = '{"beq",     32'h1109_0010, 1'b0, 5'd0,  2'b00, 3'b100, 4'b0010, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h99};
    vecs[3]  = '{"addi",    32'h2109_7FFF, 1'b0, 5'd0,  2'b10, 3'b000, 4'b0001, 1'b1, 32'h0000_7FFF, 32'hDEAD_BEEF, 32'h99};
    vecs[4]  = '{"ori",     32'h3509_FFFF, 1'b0, 5'd0,  2'b10, 3'b000, 4'b0111, 1'b1, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h99};
    vecs[5]  = '{"add",     32'h0109_5020, 1'b0, 5'd0,  2'b10, 3'b000, 4'b1100, 1'b1, 32'h0000_5020, 32'hDEAD_BEEF, 32'h99};
    vecs[6]  = '{"op3f",    32'hFC00_0000, 1'b0, 5'd0,  2'b00, 3'b000, 4'b0000, 1'b1, 32'h0000_0000, 32'h0,         32'h0};
    vecs[7]  = '{"zero",    32'h0000_0000, 1'b0, 5'd0,  2'b00, 3'b000, 4'b0000, 1'b1, 32'h0000_0000, 32'h0,         32'h0};
    // Hazard cases on add r11,r9,r10 and add r11,r0,r0
    vecs[8]  = '{"lu_rs",   32'h012A_5820, 1'b1, 5'd9,  2'b00, 3'b000, 4'b0000, 1'b0, 32'h0000_5820, 32'h99,        32'h0};
    vecs[9]  = '{"lu_rt",   32'h012A_5820, 1'b1, 5'd10, 2'b00, 3'b000, 4'b0000, 1'b0, 32'h0000_5820, 32'h99,        32'h0};
    vecs[10] = '{"no_stl0", 32'h0000_5820, 1'b1, 5'd0,  2'b10, 3'b000, 4'b1100, 1'b1, 32'h0000_5820, 32'h0,         32'h0};

    rst = 1'b1; instr_in = '0; pc_incr_in = '0; flush = 1'b0;
    idex_mem_read = 1'b0; idex_rt = '0;
    wb_reg_write = 1'b0; wb_write_reg = '0; wb_write_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // ---- Reset state ----
    check_bundles("rst0", 2'b00, 3'b000, 4'b0000);
    check("rst0.pc_write", {31'd0, pc_write}, 32'd1);
    check("rst0.pc_incr", pc_incr_out, 32'h0);
    check("rst0.read1", read1, 32'h0);
    check("rst0.read2", read2, 32'h0);
    check("rst0.sign_ext", sign_ext, 32'h0);
    check("rst0.rd_rt", {22'd0, rd_out, rt_out}, 32'h0);

    // ---- Reset clears the register file (r5) and IF/ID ----
    write_reg(5'd5, 32'h1234);
    load(32'h00A0_0820, 32'h10);
    check("r5.before_rst", read1, 32'h1234);
    instr_in = 32'h8D09_8000; pc_incr_in = 32'h200;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_bundles("rst1", 2'b00, 3'b000, 4'b0000);
    check("rst1.pc_incr", pc_incr_out, 32'h0);
    load(32'h00A0_0820, 32'h14);
    check("r5.after_rst", read1, 32'h0);

    // ---- Write-through bypass on r8 ----
    load(32'h0109_5020, 32'h20);
    wb_reg_write = 1'b1; wb_write_reg = 5'd8; wb_write_data = 32'hDEAD_BEEF;
    #1;
    check("bypass.read1", read1, 32'hDEAD_BEEF);
    check("bypass.read2", read2, 32'h0);
    @(posedge clk);
    #1 wb_reg_write = 1'b0;
    #1 check("stored.read1", read1, 32'hDEAD_BEEF);

    // ---- Writes to r0 are ignored, including the bypass path ----
    load(32'h0000_5820, 32'h24);
    wb_reg_write = 1'b1; wb_write_reg = 5'd0; wb_write_data = 32'hFFFF_FFFF;
    #1;
    check("r0.bypass", read1, 32'h0);
    @(posedge clk);
    #1 wb_reg_write = 1'b0;
    #1 check("r0.stored", read2, 32'h0);

    write_reg(5'd9, 32'h99);

    // ---- Table-driven decode / hazard sweep ----
    for (int i = 0; i < 11; i++) begin
      logic [31:0] pc_exp;
      pc_exp = 32'h1000 + 32'(i * 4);
      load(vecs[i].instr, pc_exp);
      idex_mem_read = vecs[i].mr;
      idex_rt       = vecs[i].irt;
      #1;
      check_bundles(vecs[i].name, vecs[i].wb, vecs[i].mem, vecs[i].ex);
      check({vecs[i].name, ".pc_write"}, {31'd0, pc_write}, {31'd0, vecs[i].pcw});
      check({vecs[i].name, ".sign_ext"}, sign_ext, vecs[i].sx);
      check({vecs[i].name, ".read1"}, read1, vecs[i].r1);
      check({vecs[i].name, ".read2"}, read2, vecs[i].r2);
      check({vecs[i].name, ".rt_out"}, {27'd0, rt_out}, {27'd0, vecs[i].instr[20:16]});
      check({vecs[i].name, ".rd_out"}, {27'd0, rd_out}, {27'd0, vecs[i].instr[15:11]});
      check({vecs[i].name, ".pc_incr"}, pc_incr_out, pc_exp);
      idex_mem_read = 1'b0;
      idex_rt       = '0;
    end

    // ---- Load-use: one-cycle hold, then normal decode ----
    load(32'h012A_5820, 32'h100);
    instr_in = 32'h8D09_8000; pc_incr_in = 32'h104;
    idex_mem_read = 1'b1; idex_rt = 5'd9;
    #1;
    check("lu.pc_write", {31'd0, pc_write}, 32'd0);
    check_bundles("lu", 2'b00, 3'b000, 4'b0000);
    @(posedge clk);
    #1 idex_mem_read = 1'b0; idex_rt = '0;
    #1;
    check("lu.hold_pc", pc_incr_out, 32'h100);
    check("lu.hold_rd", {27'd0, rd_out}, 32'd11);
    check("lu.resume_pcw", {31'd0, pc_write}, 32'd1);
    check_bundles("lu.resume", 2'b10, 3'b000, 4'b1100);
    @(posedge clk);
    #1 check("lu.next_pc", pc_incr_out, 32'h104);
    check_bundles("lu.next", 2'b11, 3'b010, 4'b0001);

    // ---- Flush with a concurrent load-use stall ----
    load(32'h012A_5820, 32'h108);
    flush = 1'b1; idex_mem_read = 1'b1; idex_rt = 5'd9;
    instr_in = 32'h0109_5020; pc_incr_in = 32'h10C;
    #1;
    check("fl.pc_write", {31'd0, pc_write}, 32'd1);
    check_bundles("fl", 2'b00, 3'b000, 4'b0000);
    @(posedge clk);
    #1 flush = 1'b0; idex_mem_read = 1'b0; idex_rt = '0;
    #1;
    check("fl.nop_pc", pc_incr_out, 32'h0);
    check("fl.nop_rd", {27'd0, rd_out}, 32'd0);
    check_bundles("fl.nop", 2'b00, 3'b000, 4'b0000);

    // ---- Reset asserted mid-stall: reset wins ----
    load(32'h012A_5820, 32'h300);
    idex_mem_read = 1'b1; idex_rt = 5'd9;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; idex_mem_read = 1'b0; idex_rt = '0;
    #1;
    check("rst_stall.pc_incr", pc_incr_out, 32'h0);
    check("rst_stall.rd", {27'd0, rd_out}, 32'd0);
    load(32'h0109_5020, 32'h304);
    check("rst_stall.r8", read1, 32'h0);
    check("rst_stall.r9", read2, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
